// File: rtl/bl_wl_frame_programmer.sv
// bl_wl_frame_programmer: writes one BL row per handshake then pulses its one-hot WL line; define CFG_PARITY_CHECK_EN for even-parity checking with sticky cfg_error
module bl_wl_frame_programmer #(
    parameter int BL_WIDTH        = 8,
    parameter int WL_WIDTH        = 8,
    parameter int WL_PULSE_CYCLES = 2
) (
    input  logic                prog_clk,
    input  logic                prog_rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BL_WIDTH-1:0] cfg_data,
`ifdef CFG_PARITY_CHECK_EN
    input  logic                cfg_parity,
    output logic                cfg_error,
`endif
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl
);
    localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PW = $clog2(WL_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, HOLD, DONE} state_t;

    state_t              state, state_n;
    logic [RW-1:0]       row, row_n;
    logic [PW-1:0]       pcnt, pcnt_n;
    logic [BL_WIDTH-1:0] bl_n;
    logic                xfer, bad;

    assign xfer = cfg_ready && cfg_valid;
`ifdef CFG_PARITY_CHECK_EN
    assign bad = cfg_parity ^ (^cfg_data);
`else
    assign bad = 1'b0;
`endif

    // next state, row/pulse counters and bit-line data; bl is cleared whenever the frame is not active
    always_comb begin
        state_n = state;
        row_n   = row;
        pcnt_n  = pcnt;
        bl_n    = bl;
        case (state)
            IDLE: if (cfg_start) begin
                state_n = LOAD;
                row_n   = '0;
            end
            LOAD: if (xfer) begin
                state_n = SETUP;
                bl_n    = bad ? '0 : cfg_data;
            end
            SETUP: begin
                state_n = PULSE;
                pcnt_n  = PW'(WL_PULSE_CYCLES);
            end
            PULSE: begin
                pcnt_n  = pcnt - 1'b1;
                state_n = (pcnt == PW'(1)) ? HOLD : PULSE;
            end
            HOLD: begin
                state_n = (row == RW'(WL_WIDTH - 1)) ? DONE : LOAD;
                row_n   = (row == RW'(WL_WIDTH - 1)) ? row : row + 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE || state_n == DONE) bl_n = '0;
    end

    // state and registered outputs, all decoded from the next state so they change cleanly on the edge
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= IDLE;
            row       <= '0;
            pcnt      <= '0;
            bl        <= '0;
            wl        <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            pcnt      <= pcnt_n;
            bl        <= bl_n;
            wl        <= (state_n == PULSE) ? WL_WIDTH'(1) << row_n : '0;
            cfg_ready <= state_n == LOAD;
            cfg_busy  <= state_n != IDLE;
            cfg_done  <= state_n == DONE;
        end
    end

`ifdef CFG_PARITY_CHECK_EN
    // sticky parity error, cleared only by reset or an accepted frame start
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) cfg_error <= 1'b0;
        else if (state == IDLE && cfg_start) cfg_error <= 1'b0;
        else if (xfer && bad) cfg_error <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_bl_wl_frame_programmer.sv
// tb_bl_wl_frame_programmer: scoreboard bench for bl_wl_frame_programmer (default and CFG_PARITY_CHECK_EN builds)
module tb_bl_wl_frame_programmer;
    localparam int BW = 8;
    localparam int WW = 8;
    localparam int P  = 2;
`ifdef CFG_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          prog_clk = 1'b0;
    logic          prog_rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [BW-1:0] cfg_data = '0;
    logic          cfg_ready, cfg_busy, cfg_done;
    logic [BW-1:0] bl;
    logic [WW-1:0] wl;
    logic          s_start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, s_busy, s_done;
    logic [7:0]    s_bl;
    logic [0:0]    s_wl;
`ifdef CFG_PARITY_CHECK_EN
    logic          cfg_parity = 1'b0;
    logic          cfg_error, s_error;
    bit            frame_bad = 1'b0;
`endif

    typedef struct {
        int            cyc;
        logic [WW-1:0] wl;
        logic [BW-1:0] bl;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    exp_row = 0;
    beat_t beat_q[$];
    int    done_q[$];

    bl_wl_frame_programmer #(.BL_WIDTH(BW), .WL_WIDTH(WW), .WL_PULSE_CYCLES(P)) u_dut (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data),
`ifdef CFG_PARITY_CHECK_EN
        .cfg_parity(cfg_parity), .cfg_error(cfg_error),
`endif
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .bl(bl), .wl(wl)
    );

    bl_wl_frame_programmer #(.BL_WIDTH(8), .WL_WIDTH(1), .WL_PULSE_CYCLES(4)) u_small (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .cfg_start(s_start), .cfg_valid(s_valid),
        .cfg_ready(s_ready), .cfg_data(s_data),
`ifdef CFG_PARITY_CHECK_EN
        .cfg_parity(^s_data), .cfg_error(s_error),
`endif
        .cfg_busy(s_busy), .cfg_done(s_done), .bl(s_bl), .wl(s_wl)
    );

    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected WL beats and done pulses whenever the DUT presents them
    initial begin
        beat_t         b;
        logic [BW-1:0] prev_bl = '0;
        logic [WW-1:0] prev_wl = '0;
        forever begin
            @(negedge prog_clk);
            if (prog_rst_n) begin
                check("wl_onehot", 32'($countones(wl) <= 1), 1);
                if (bl != prev_bl) check("bl_change_while_wl", 32'(wl == 0 && prev_wl == 0), 1);
                while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
                    b = beat_q.pop_front();
                    checks++; errors++;
                    $display("FAIL wl_missing: no pulse seen, expected wl=%0h bl=%0h at cycle %0d", b.wl, b.bl, b.cyc);
                end
                while (done_q.size() > 0 && done_q[0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL done_missing: no cfg_done seen, expected at cycle %0d", done_q.pop_front());
                end
                if (wl != 0) begin
                    if (beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wl_unexpected: got wl=%0h expected no pulse at cycle %0d", wl, cyc);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_cycle", cyc, b.cyc);
                        check("beat_wl", wl, b.wl);
                        check("beat_bl", bl, b.bl);
                    end
                end
                if (cfg_done) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got cfg_done=1 expected 0 at cycle %0d", cyc);
                    end else begin
                        check("done_cycle", cyc, done_q.pop_front());
                        check("done_bl", bl, 0);
                    end
                end
                prev_bl = bl;
                prev_wl = wl;
            end else begin
                prev_bl = '0;
                prev_wl = '0;
            end
        end
    end

    task automatic start_frame();
        @(negedge prog_clk);
        check("idle_busy", cfg_busy, 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = BW'($urandom);
`ifdef CFG_PARITY_CHECK_EN
        cfg_parity = 1'($urandom);
        frame_bad  = 1'b0;
`endif
        @(negedge prog_clk);
        cfg_start = 1'b0;
        check("start_busy", cfg_busy, 1);
`ifdef CFG_PARITY_CHECK_EN
        check("start_clears_error", cfg_error, 0);
`endif
        exp_row = 0;
    endtask

    task automatic send_row(input logic [BW-1:0] d, input int gap, input bit bad, input bit poke_start);
        int    n = 0;
        beat_t nb;
        cfg_data  = d;
        cfg_valid = (gap == 0);
`ifdef CFG_PARITY_CHECK_EN
        cfg_parity = (^d) ^ bad;
        frame_bad  = frame_bad | bad;
`endif
        if (poke_start) begin
            cfg_start = 1'b1;
            @(negedge prog_clk);
            cfg_start = 1'b0;
        end
        while (!cfg_ready && n < 50) begin
            @(negedge prog_clk);
            n++;
        end
        check("ready_wait", cfg_ready, 1);
        for (int i = 0; i < gap; i++) begin
            check("gap_ready", cfg_ready, 1);
            check("gap_wl", wl, 0);
            @(negedge prog_clk);
        end
        cfg_valid = 1'b1;
        for (int i = 0; i < P; i++) begin
            nb.cyc = cyc + 2 + i;
            nb.wl  = WW'(1) << exp_row;
            nb.bl  = (bad && PAR) ? '0 : d;
            beat_q.push_back(nb);
        end
        if (exp_row == WW - 1) done_q.push_back(cyc + 3 + P);
        exp_row++;
        @(negedge prog_clk);
        check("ready_drops", cfg_ready, 0);
`ifdef CFG_PARITY_CHECK_EN
        if (bad) check("error_set", cfg_error, 1);
`endif
    endtask

    task automatic finish_frame();
        int n = 0;
        while ((done_q.size() > 0 || beat_q.size() > 0) && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("frame_drained", done_q.size() + beat_q.size(), 0);
        beat_q.delete();
        done_q.delete();
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        check("end_busy", cfg_busy, 0);
        check("end_bl", bl, 0);
        check("end_ready", cfg_ready, 0);
`ifdef CFG_PARITY_CHECK_EN
        check("error_sticky", cfg_error, frame_bad);
`endif
    endtask

    task automatic small_test();
        int t, n = 0, first = -1, hi = 0, dcyc = -1;
        @(negedge prog_clk);
        s_start = 1'b1;
        @(negedge prog_clk);
        s_start = 1'b0;
        s_data  = 8'h3C;
        s_valid = 1'b1;
        while (!s_ready && n < 20) begin
            @(negedge prog_clk);
            n++;
        end
        check("small_ready", s_ready, 1);
        t = cyc;
        @(negedge prog_clk);
        s_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (s_wl[0]) begin
                if (first < 0) first = cyc;
                hi++;
                check("small_bl", s_bl, 8'h3C);
            end
            if (s_done) dcyc = cyc;
            @(negedge prog_clk);
        end
        check("small_wl_start", first, t + 2);
        check("small_wl_len", hi, 4);
        check("small_done", dcyc, t + 7);
        check("small_idle", s_busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge prog_clk);
        check("rst_ready", cfg_ready, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_bl", bl, 0);
        check("rst_wl", wl, 0);
        check("rst_small_wl", s_wl, 0);
        prog_rst_n = 1'b1;
        small_test();
        start_frame();
        for (int r = 0; r < WW; r++) send_row(BW'(1 << r), 0, 1'b0, r == 3);
        finish_frame();
        start_frame();
        for (int r = 0; r < WW; r++)
            send_row(r == 4 ? 8'hA5 : r == 5 ? 8'h03 : BW'($urandom), r == 4 ? 5 : 0, r == 5, 1'b0);
        finish_frame();
        for (int f = 0; f < 3; f++) begin
            start_frame();
            for (int r = 0; r < WW; r++) send_row(BW'($urandom), $urandom_range(0, 3), $urandom_range(0, 5) == 0, 1'b0);
            finish_frame();
        end
        start_frame();
        for (int r = 0; r < 4; r++) send_row(BW'($urandom), 0, 1'b0, 1'b0);
        n = 0;
        while (wl == 0 && n < 10) begin
            @(negedge prog_clk);
            n++;
        end
        check("pre_reset_wl", wl, 8'h08);
        #2 prog_rst_n = 1'b0;
        #1 check("reset_wl_async", wl, 0);
        check("reset_busy", cfg_busy, 0);
        check("reset_bl", bl, 0);
        beat_q.delete();
        done_q.delete();
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        cfg_valid  = 1'b1;
        repeat (3) begin
            @(negedge prog_clk);
            check("post_reset_ready", cfg_ready, 0);
            check("post_reset_busy", cfg_busy, 0);
        end
`ifdef CFG_PARITY_CHECK_EN
        check("post_reset_error", cfg_error, 0);
`endif
        start_frame();
        for (int r = 0; r < WW; r++) send_row(BW'($urandom), $urandom_range(0, 2), $urandom_range(0, 7) == 0, 1'b0);
        finish_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected $finish");
        $fatal(1, "watchdog");
    end
endmodule
